bandai2003_cfg_ctrl: RTL

Host-side configuration controller for the BANDAI2003 cartridge mapper. It resets the mapper, runs the two-step address unlock, captures and checks the 18-bit serial bitstream on SO, then serves queued bank-register read and write commands (LAO/RAM/ROM0/ROM1) over the mapper's CEn/OEn/WEn/DQ bus. It sits between the system bus glue and the cartridge connector, and is the only master of the mapper's control pins.

---
 rtl/bandai2003_pkg.sv | 36 +++
 rtl/bandai2003_so_capture.sv | 39 +++
 rtl/bandai2003_cfg_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bandai2003_pkg.sv
// rtl/bandai2003_pkg.sv - shared mapper addresses, stream default and FSM states
package bandai2003_pkg;

  localparam logic [7:0] ADDR_IDLE = 8'h00;
  localparam logic [7:0] ADDR_ACK  = 8'h5A;
  localparam logic [7:0] ADDR_NAK  = 8'hA5;
  localparam logic [7:0] ADDR_NIH  = 8'hFF;
  localparam logic [7:0] ADDR_LAO  = 8'hC0;
  localparam logic [7:0] ADDR_RAM  = 8'hC1;
  localparam logic [7:0] ADDR_ROM0 = 8'hC2;
  localparam logic [7:0] ADDR_ROM1 = 8'hC3;

  localparam logic [17:0] DEF_STREAM = 18'h05140;

  typedef enum logic [3:0] {
    IDLE,
    MRST,
    ACK,
    NAK,
    CAP,
    CHECK,
    READY,
    W_SET,
    W_STB,
    W_HLD,
    R_SET,
    R_STB,
    R_DONE,
    FAIL
  } state_t;

  function automatic logic [7:0] bank_addr(input logic [1:0] idx);
    return ADDR_LAO | {6'b000000, idx};
  endfunction

endpackage

// File: rtl/bandai2003_so_capture.sv
// rtl/bandai2003_so_capture.sv - serial SO capture shift register, sample counter and compare
module bandai2003_so_capture
  import bandai2003_pkg::*;
#(
  parameter int                  CAP_BITS   = 18,
  parameter logic [CAP_BITS-1:0] EXP_STREAM = DEF_STREAM
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic shift_en,
  input  logic so,
  output logic last,
  output logic done,
  output logic match
);

  logic [CAP_BITS-1:0] shreg;
  logic [4:0]          cnt;

  // New bit enters the MSB so the first bit received settles in bit 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg <= '0;
      cnt   <= 5'd0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= 5'd0;
    end else if (shift_en && !done) begin
      shreg <= {so, shreg[CAP_BITS-1:1]};
      cnt   <= cnt + 5'd1;
    end
  end

  assign last  = shift_en & (cnt == 5'(CAP_BITS - 1));
  assign done  = (cnt == 5'(CAP_BITS));
  assign match = (shreg == EXP_STREAM);

endmodule

// File: rtl/bandai2003_cfg_ctrl.sv
// rtl/bandai2003_cfg_ctrl.sv - BANDAI2003 mapper reset/unlock, bitstream check and bank register access
module bandai2003_cfg_ctrl
  import bandai2003_pkg::*;
#(
  parameter int                  STB_CYCLES = 2,
  parameter int                  CAP_BITS   = 18,
  parameter logic [CAP_BITS-1:0] EXP_STREAM = DEF_STREAM
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_WRITE,
  input  logic [1:0] CMD_IDX,
  input  logic [7:0] CMD_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       UNLOCKED,
  output logic       ERROR,
  output logic       M_RSTn,
  output logic       M_CEn,
  output logic       M_SSn,
  output logic       M_OEn,
  output logic       M_WEn,
  output logic [7:0] M_ADDR,
  output logic [7:0] M_DQ_O,
  output logic       M_DQ_OE,
  input  logic [7:0] M_DQ_I,
  input  logic       M_SO
);

  state_t     state, state_nxt;
  logic [3:0] stb_cnt, stb_cnt_nxt;
  logic [1:0] idx_q, idx_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic       accept;
  logic       cap_shift, cap_last, cap_done, cap_match;

  logic       rstn_nxt, cen_nxt, oen_nxt, wen_nxt, dq_oe_nxt;
  logic       ready_nxt, rsp_valid_nxt, unlocked_nxt, error_nxt;
  logic [7:0] addr_nxt, dq_o_nxt, rdata_nxt;

  // START outranks a same-cycle handshake, so the command is simply dropped.
  assign accept    = (state == READY) & CMD_VALID & ~START;
  assign cap_shift = (state == CAP);
  assign M_SSn     = 1'b1;

  bandai2003_so_capture #(
    .CAP_BITS  (CAP_BITS),
    .EXP_STREAM(EXP_STREAM)
  ) u_cap (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (START),
    .shift_en(cap_shift),
    .so      (M_SO),
    .last    (cap_last),
    .done    (cap_done),
    .match   (cap_match)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      stb_cnt   <= 4'd0;
      idx_q     <= 2'd0;
      wdata_q   <= 8'h00;
      M_RSTn    <= 1'b0;
      M_CEn     <= 1'b1;
      M_OEn     <= 1'b1;
      M_WEn     <= 1'b1;
      M_ADDR    <= ADDR_IDLE;
      M_DQ_O    <= 8'h00;
      M_DQ_OE   <= 1'b0;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= 8'h00;
      UNLOCKED  <= 1'b0;
      ERROR     <= 1'b0;
    end else begin
      state     <= state_nxt;
      stb_cnt   <= stb_cnt_nxt;
      idx_q     <= idx_nxt;
      wdata_q   <= wdata_nxt;
      M_RSTn    <= rstn_nxt;
      M_CEn     <= cen_nxt;
      M_OEn     <= oen_nxt;
      M_WEn     <= wen_nxt;
      M_ADDR    <= addr_nxt;
      M_DQ_O    <= dq_o_nxt;
      M_DQ_OE   <= dq_oe_nxt;
      CMD_READY <= ready_nxt;
      RSP_VALID <= rsp_valid_nxt;
      RSP_RDATA <= rdata_nxt;
      UNLOCKED  <= unlocked_nxt;
      ERROR     <= error_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    stb_cnt_nxt  = stb_cnt;
    idx_nxt      = idx_q;
    wdata_nxt    = wdata_q;
    unlocked_nxt = UNLOCKED;
    error_nxt    = ERROR;
    rdata_nxt    = RSP_RDATA;

    if (START) begin
      state_nxt    = MRST;
      unlocked_nxt = 1'b0;
      error_nxt    = 1'b0;
    end else begin
      case (state)
        MRST:  state_nxt = ACK;
        ACK:   state_nxt = NAK;
        NAK:   state_nxt = CAP;
        CAP:   if (cap_last) state_nxt = CHECK;
        CHECK: begin
          if (cap_done && cap_match) begin
            state_nxt    = READY;
            unlocked_nxt = 1'b1;
          end else begin
            state_nxt = FAIL;
            error_nxt = 1'b1;
          end
        end
        READY: begin
          if (accept) begin
            state_nxt = CMD_WRITE ? W_SET : R_SET;
            idx_nxt   = CMD_IDX;
            wdata_nxt = CMD_WRITE ? CMD_WDATA : 8'h00;
          end
        end
        W_SET: begin
          state_nxt   = W_STB;
          stb_cnt_nxt = 4'(STB_CYCLES - 1);
        end
        W_STB: begin
          if (stb_cnt == 4'd0) state_nxt = W_HLD;
          else stb_cnt_nxt = stb_cnt - 4'd1;
        end
        W_HLD: state_nxt = READY;
        R_SET: begin
          state_nxt   = R_STB;
          stb_cnt_nxt = 4'(STB_CYCLES - 1);
        end
        R_STB: begin
          if (stb_cnt == 4'd0) state_nxt = R_DONE;
          else stb_cnt_nxt = stb_cnt - 4'd1;
        end
        R_DONE: state_nxt = READY;
        IDLE, FAIL: state_nxt = state;
        default: state_nxt = IDLE;
      endcase
    end

    // Registered outputs are decoded from the state being entered.
    rstn_nxt      = 1'b1;
    cen_nxt       = 1'b1;
    oen_nxt       = 1'b1;
    wen_nxt       = 1'b1;
    dq_oe_nxt     = 1'b0;
    dq_o_nxt      = 8'h00;
    addr_nxt      = ADDR_IDLE;
    ready_nxt     = 1'b0;
    rsp_valid_nxt = 1'b0;

    case (state_nxt)
      IDLE, MRST, FAIL: rstn_nxt = 1'b0;
      ACK:   addr_nxt = ADDR_ACK;
      NAK:   addr_nxt = ADDR_NAK;
      READY: ready_nxt = 1'b1;
      W_SET, W_HLD: begin
        cen_nxt   = 1'b0;
        addr_nxt  = bank_addr(idx_nxt);
        dq_oe_nxt = 1'b1;
        dq_o_nxt  = wdata_nxt;
      end
      W_STB: begin
        cen_nxt   = 1'b0;
        wen_nxt   = 1'b0;
        addr_nxt  = bank_addr(idx_nxt);
        dq_oe_nxt = 1'b1;
        dq_o_nxt  = wdata_nxt;
      end
      R_SET: begin
        cen_nxt  = 1'b0;
        addr_nxt = bank_addr(idx_nxt);
      end
      R_STB: begin
        cen_nxt  = 1'b0;
        oen_nxt  = 1'b0;
        addr_nxt = bank_addr(idx_nxt);
      end
      R_DONE: begin
        // OEn is still low on this edge, so DQ carries the register value.
        cen_nxt       = 1'b0;
        addr_nxt      = bank_addr(idx_nxt);
        rsp_valid_nxt = 1'b1;
        rdata_nxt     = M_DQ_I;
      end
      default: ;
    endcase
  end

endmodule
